// File: rtl/au_req_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle arithmetic unit.
// One operation in flight; divide-by-zero short-circuits and a hung unit is timed out.
module au_req_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             au_start,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic [1:0]       au_op,
    input  logic             au_done,
    input  logic [WIDTH-1:0] au_hi,
    input  logic [WIDTH-1:0] au_lo,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_hi,
    output logic [WIDTH-1:0] rsp_lo,
    output logic             rsp_zero,
    output logic             rsp_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]       state_reg, state_next;
    logic             rr_ptr_reg, rr_ptr_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [1:0]       op_reg, op_next;
    logic             id_reg, id_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic             rsp_id_reg, rsp_id_next;
    logic [WIDTH-1:0] rsp_hi_reg, rsp_hi_next;
    logic [WIDTH-1:0] rsp_lo_reg, rsp_lo_next;
    logic             rsp_zero_reg, rsp_zero_next;
    logic             rsp_err_reg, rsp_err_next;

    logic             any_valid;
    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] done_hi;

    assign any_valid = |req_valid;
    assign grant_id  = (req_valid == 2'b11) ? rr_ptr_reg : req_valid[1];
    assign accept    = (state_reg == S_IDLE) && any_valid;
    assign sel_a     = grant_id ? req1_a  : req0_a;
    assign sel_b     = grant_id ? req1_b  : req0_b;
    assign sel_op    = grant_id ? req1_op : req0_op;

    // Add/sub results live on lo only; whatever the unit leaves on hi is discarded.
    assign done_hi = op_reg[1] ? au_hi : '0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant_id == gi[0]);
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        cnt_next       = cnt_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        op_next        = op_reg;
        id_next        = id_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_id_next    = rsp_id_reg;
        rsp_hi_next    = rsp_hi_reg;
        rsp_lo_next    = rsp_lo_reg;
        rsp_zero_next  = rsp_zero_reg;
        rsp_err_next   = rsp_err_reg;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    a_next  = sel_a;
                    b_next  = sel_b;
                    op_next = sel_op;
                    id_next = grant_id;
                    if (sel_op == 2'b11 && sel_b == '0) begin
                        rsp_valid_next = 1'b1;
                        rsp_id_next    = grant_id;
                        rsp_hi_next    = '0;
                        rsp_lo_next    = '0;
                        rsp_zero_next  = 1'b0;
                        rsp_err_next   = 1'b1;
                        state_next     = S_RESP;
                    end else begin
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_next   = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                cnt_next = cnt_reg + 1'b1;
                // A done arriving on the timeout cycle still counts as a good result.
                if (au_done) begin
                    rsp_valid_next = 1'b1;
                    rsp_id_next    = id_reg;
                    rsp_hi_next    = done_hi;
                    rsp_lo_next    = au_lo;
                    rsp_zero_next  = (done_hi == '0) && (au_lo == '0);
                    rsp_err_next   = 1'b0;
                    state_next     = S_RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    rsp_valid_next = 1'b1;
                    rsp_id_next    = id_reg;
                    rsp_hi_next    = '0;
                    rsp_lo_next    = '0;
                    rsp_zero_next  = 1'b0;
                    rsp_err_next   = 1'b1;
                    state_next     = S_RESP;
                end
            end
            default: begin
                if (rsp_valid_reg && rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    rr_ptr_next    = ~rsp_id_reg;
                    state_next     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            rr_ptr_reg    <= 1'b0;
            cnt_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= '0;
            id_reg        <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_hi_reg    <= '0;
            rsp_lo_reg    <= '0;
            rsp_zero_reg  <= 1'b0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            cnt_reg       <= cnt_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            op_reg        <= op_next;
            id_reg        <= id_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_id_reg    <= rsp_id_next;
            rsp_hi_reg    <= rsp_hi_next;
            rsp_lo_reg    <= rsp_lo_next;
            rsp_zero_reg  <= rsp_zero_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign au_start  = (state_reg == S_ISSUE);
    assign au_a      = a_reg;
    assign au_b      = b_reg;
    assign au_op     = op_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_hi    = rsp_hi_reg;
    assign rsp_lo    = rsp_lo_reg;
    assign rsp_zero  = rsp_zero_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_au_req_arbiter.sv
// Bench for au_req_arbiter: directed cases then random traffic, with the arithmetic
// unit emulated in-line and expected responses computed from plain arithmetic.
module tb_au_req_arbiter;
    localparam int W  = 32;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]   req0_op, req1_op;
    logic         au_start;
    logic [W-1:0] au_a, au_b;
    logic [1:0]   au_op;
    logic         au_done;
    logic [W-1:0] au_hi, au_lo;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [W-1:0] rsp_hi, rsp_lo;

    int checks   = 0;
    int failures = 0;
    bit next_pref = 1'b0;   // requester that wins the next tie

    always #5 clk = ~clk;

    au_req_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .au_start(au_start), .au_a(au_a), .au_b(au_b), .au_op(au_op),
        .au_done(au_done), .au_hi(au_hi), .au_lo(au_lo),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // What the requester should get back, from the arithmetic meaning of the opcode.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit hang, output logic [W-1:0] hi, output logic [W-1:0] lo,
                                  output logic z, output logic e);
        logic [2*W-1:0] p;
        hi = '0; lo = '0; z = 1'b0; e = 1'b0;
        if (hang || (op == 2'd3 && b == '0)) begin
            e = 1'b1;
        end else begin
            case (op)
                2'd0: lo = a + b;
                2'd1: lo = a - b;
                2'd2: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; hi = p[2*W-1:W]; lo = p[W-1:0]; end
                default: begin hi = a % b; lo = a / b; end
            endcase
            z = (hi == '0) && (lo == '0);
        end
    endfunction

    task automatic set_req(input bit id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id) begin req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_op = op; req0_a = a; req0_b = b; end
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge after the handshake.
    // lat<0 means the unit never answers.
    task automatic txn(input bit rid, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int lat, input int hold, input bit both);
        logic [W-1:0]   e_hi, e_lo;
        logic           e_z, e_e;
        logic [2*W+3:0] e_rsp;
        logic [1:0]     e_rdy;
        bit             dz;
        model(op, a, b, lat < 0, e_hi, e_lo, e_z, e_e);
        e_rsp = {1'b1, rid, e_e, e_z, e_hi, e_lo};
        e_rdy = rid ? 2'b10 : 2'b01;
        dz    = (op == 2'd3) && (b == '0);
        set_req(rid, op, a, b);
        req_valid[rid] = 1'b1;
        if (both) req_valid[~rid] = 1'b1;
        #1;
        chk("grant", 128'(req_ready), 128'(e_rdy));
        @(negedge clk);
        req_valid[rid] = 1'b0;
        chk("start", 128'(au_start), 128'(!dz));
        chk("ready_busy", 128'(req_ready), 128'(2'b00));
        if (!dz) begin
            chk("au_operands", 128'({au_op, au_a, au_b}), 128'({op, a, b}));
            if (lat < 0) begin
                for (int i = 1; i <= TO; i++) begin
                    @(negedge clk);
                    if (i == 1) chk("start_pulse", 128'(au_start), 128'(1'b0));
                end
                chk("timeout_early", 128'(rsp_valid), 128'(1'b0));
                @(negedge clk);
            end else begin
                for (int i = 1; i <= lat; i++) begin
                    @(negedge clk);
                    if (i == 1) chk("start_pulse", 128'(au_start), 128'(1'b0));
                end
                chk("rsp_early", 128'(rsp_valid), 128'(1'b0));
                au_done = 1'b1;
                au_hi   = op[1] ? e_hi : $urandom;
                au_lo   = e_lo;
                @(negedge clk);
                au_done = 1'b0;
            end
        end
        chk("rsp", 128'({rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_hi, rsp_lo}), 128'(e_rsp));
        for (int h = 0; h < hold; h++) begin
            if (lat < 0 && h == 0) begin
                au_done = 1'b1; au_hi = $urandom; au_lo = $urandom;
            end
            @(negedge clk);
            au_done = 1'b0;
            chk("rsp_hold", 128'({rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_hi, rsp_lo}), 128'(e_rsp));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", 128'(rsp_valid), 128'(1'b0));
        next_pref = ~rid;
        $display("txn id=%0d op=%0d a=%h b=%h hi=%h lo=%h zero=%0b err=%0b", rid, op, a, b, e_hi, e_lo, e_z, e_e);
    endtask

    logic [1:0]   r_op, o_op;
    logic [W-1:0] r_a, r_b, o_a, o_b;
    bit           r_both, r_id;

    initial begin
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; au_done = 1'b0; au_hi = '0; au_lo = '0;
        set_req(1'b0, 2'd0, '0, '0);
        set_req(1'b1, 2'd0, '0, '0);
        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'({req_ready, au_start, au_a, au_b, au_op, rsp_valid, rsp_id,
                                   rsp_hi, rsp_lo, rsp_zero, rsp_err}), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        txn(1'b0, 2'd0, 32'd5, 32'd7, 1, 0, 1'b0);          // ADD, unit latency 1
        txn(1'b1, 2'd3, 32'd100, 32'd0, 0, 0, 1'b0);        // DIV by zero
        set_req(1'b1, 2'd2, 32'd6, 32'd7);
        txn(1'b0, 2'd0, 32'd11, 32'd22, 2, 1, 1'b1);        // tie with pointer at req0
        txn(1'b1, 2'd2, 32'd6, 32'd7, 1, 0, 1'b0);
        txn(1'b0, 2'd1, 32'd9, 32'd9, 3, 0, 1'b0);          // SUB to zero
        set_req(1'b0, 2'd2, 32'h10000, 32'h10000);
        txn(1'b1, 2'd3, 32'd100, 32'd7, 2, 0, 1'b1);        // tie with pointer at req1
        txn(1'b0, 2'd2, 32'h10000, 32'h10000, 1, 1, 1'b0);  // MUL into hi
        txn(1'b0, 2'd0, 32'd1, 32'd1, -1, 3, 1'b0);         // unit hangs

        // Stray done while idle must not produce a response.
        au_done = 1'b1; au_lo = 32'h1234;
        @(negedge clk);
        au_done = 1'b0;
        chk("idle_done_ignored", 128'({rsp_valid, au_start}), 128'(2'b00));

        // Reset while the unit is busy.
        set_req(1'b0, 2'd0, 32'd1, 32'd2);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_in_wait", 128'({req_ready, au_start, au_a, au_b, au_op, rsp_valid, rsp_id,
                                   rsp_hi, rsp_lo, rsp_zero, rsp_err}), 128'(0));
        rst = 1'b0; next_pref = 1'b0;
        au_done = 1'b1; au_lo = 32'd3;
        @(negedge clk);
        au_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("late_done_ignored", 128'(rsp_valid), 128'(1'b0));
        txn(1'b1, 2'd2, 32'hFFFF_FFFF, 32'd3, 2, 5, 1'b0);  // long consumer stall

        for (int n = 0; n < 30; n++) begin
            r_both = ($urandom_range(0, 2) == 0);
            r_op   = 2'($urandom_range(0, 3));
            r_a    = $urandom;
            r_b    = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
            if (r_both) begin
                o_op = 2'($urandom_range(0, 3)); o_a = $urandom; o_b = $urandom_range(0, 50);
                r_id = next_pref;
                set_req(~r_id, o_op, o_a, o_b);
                txn(r_id, r_op, r_a, r_b, $urandom_range(1, 4), $urandom_range(0, 2), 1'b1);
                txn(~r_id, o_op, o_a, o_b, $urandom_range(1, 4), $urandom_range(0, 2), 1'b0);
            end else begin
                r_id = 1'($urandom_range(0, 1));
                txn(r_id, r_op, r_a, r_b, ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(1, 4),
                    $urandom_range(0, 2), 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
